calc_op_sequencer: RTL and testbench



---
 rtl/calc_op_sequencer.sv | 176 +++++++++++++++++
 tb/tb_calc_op_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_op_sequencer.sv
// Calculator operation sequencer: add/sub complete locally, mul/div/sqrt are
// dispatched to shared units through an INIT/DONE handshake with a timeout.
module calc_op_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic             err_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] opa_o,
  output logic [WIDTH-1:0] opb_o,
  output logic             init_mul_o,
  output logic             init_div_o,
  output logic             init_raiz_o,
  input  logic             done_mul_i,
  input  logic             done_div_i,
  input  logic             done_raiz_i,
  input  logic [WIDTH-1:0] res_mul_i,
  input  logic [WIDTH-1:0] res_div_i,
  input  logic [WIDTH-1:0] res_raiz_i
);

  localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_SQRT = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_ARM, S_LAUNCH, S_WAIT, S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             sel_done;
  logic [WIDTH-1:0] sel_res;
  logic             timeout;

  // Only the unit addressed by the latched opcode is ever listened to.
  always_comb begin
    sel_done = 1'b0;
    sel_res  = '0;
    case (op_q)
      OP_MUL:  begin sel_done = done_mul_i;  sel_res = res_mul_i;  end
      OP_DIV:  begin sel_done = done_div_i;  sel_res = res_div_i;  end
      OP_SQRT: begin sel_done = done_raiz_i; sel_res = res_raiz_i; end
      default: ;
    endcase
  end

  assign timeout = (cnt_q == TMAX);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    err_d    = err_q;

    // Counter saturates at TIMEOUT so it can never wrap.
    if ((state_q == S_ARM || state_q == S_LAUNCH || state_q == S_WAIT) && !timeout)
      cnt_d = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          opa_d   = a_i;
          opb_d   = b_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (op_q)
          OP_ADD: begin
            result_d = opa_q + opb_q;
            state_d  = S_RESP;
          end
          OP_SUB: begin
            result_d = opa_q - opb_q;
            state_d  = S_RESP;
          end
          OP_MUL, OP_SQRT: state_d = S_ARM;
          OP_DIV: begin
            if (opb_q == '0) begin
              err_d    = 1'b1;
              result_d = '0;
              state_d  = S_RESP;
            end else begin
              state_d = S_ARM;
            end
          end
          default: begin
            err_d    = 1'b1;
            result_d = '0;
            state_d  = S_RESP;
          end
        endcase
      end
      S_ARM: begin
        // A DONE still held from an earlier request must drop before relaunching.
        if (timeout) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_RESP;
        end else if (!sel_done) begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT: begin
        if (timeout) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = S_RESP;
        end else if (sel_done) begin
          result_d = sel_res;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign valid_o     = (state_q == S_RESP);
  assign err_o       = valid_o & err_q;
  assign result_o    = result_q;
  assign opa_o       = opa_q;
  assign opb_o       = opb_q;
  assign init_mul_o  = (state_q == S_LAUNCH) && (op_q == OP_MUL);
  assign init_div_o  = (state_q == S_LAUNCH) && (op_q == OP_DIV);
  assign init_raiz_o = (state_q == S_LAUNCH) && (op_q == OP_SQRT);

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Testbench for calc_op_sequencer: directed cases plus random requests checked
// against a cycle-level transaction model and behavioural unit models.
module tb_calc_op_sequencer;
  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 255;

  logic             clk = 1'b0;
  logic             rst_i, start_i;
  logic [2:0]       op_i;
  logic [WIDTH-1:0] a_i, b_i;
  logic             busy_o, valid_o, err_o;
  logic [WIDTH-1:0] result_o, opa_o, opb_o;
  logic             init_mul_o, init_div_o, init_raiz_o;
  logic             done_mul_i = 1'b0, done_div_i = 1'b0, done_raiz_i = 1'b0;
  logic [WIDTH-1:0] res_mul_i = '0, res_div_i = '0, res_raiz_i = '0;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;

  int               delayCfg[3] = '{5, 5, 5};
  int               holdCfg[3]  = '{3, 3, 3};
  int               winStart[3] = '{0, 0, 0};
  int               winEnd[3]   = '{0, 0, 0};
  logic [WIDTH-1:0] uA[3];
  logic [WIDTH-1:0] uB[3];
  logic [2:0]       initVec;

  calc_op_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .valid_o(valid_o), .err_o(err_o), .result_o(result_o),
    .opa_o(opa_o), .opb_o(opb_o),
    .init_mul_o(init_mul_o), .init_div_o(init_div_o), .init_raiz_o(init_raiz_o),
    .done_mul_i(done_mul_i), .done_div_i(done_div_i), .done_raiz_i(done_raiz_i),
    .res_mul_i(res_mul_i), .res_div_i(res_div_i), .res_raiz_i(res_raiz_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign initVec = {init_raiz_o, init_div_o, init_mul_o};

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] isqrt(input logic [WIDTH-1:0] v);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return WIDTH'(r);
  endfunction

  // Arithmetic meaning of each unit: 0 mul, 1 div, 2 sqrt.
  function automatic logic [WIDTH-1:0] unitResult(input int u, input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (u)
      0:       r = x * y;
      1:       r = (y == '0) ? '1 : x / y;
      default: r = isqrt(x);
    endcase
    return r;
  endfunction

  // Unit models: after INIT, DONE rises delayCfg cycles later for holdCfg cycles.
  always begin
    @(posedge clk);
    #1;
    for (int u = 0; u < 3; u++) begin
      if (initVec[u]) begin
        winStart[u] = cyc + delayCfg[u];
        winEnd[u]   = winStart[u] + holdCfg[u];
        uA[u]       = opa_o;
        uB[u]       = opb_o;
      end
    end
    done_mul_i  = (cyc >= winStart[0]) && (cyc < winEnd[0]);
    done_div_i  = (cyc >= winStart[1]) && (cyc < winEnd[1]);
    done_raiz_i = (cyc >= winStart[2]) && (cyc < winEnd[2]);
    res_mul_i   = done_mul_i  ? unitResult(0, uA[0], uB[0]) : WIDTH'($urandom);
    res_div_i   = done_div_i  ? unitResult(1, uA[1], uB[1]) : WIDTH'($urandom);
    res_raiz_i  = done_raiz_i ? unitResult(2, uA[2], uB[2]) : WIDTH'($urandom);
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"},   32'(busy_o), 0);
    checkOutput({tag, "_valid"},  32'(valid_o), 0);
    checkOutput({tag, "_err"},    32'(err_o), 0);
    checkOutput({tag, "_result"}, 32'(result_o), 0);
    checkOutput({tag, "_opa"},    32'(opa_o), 0);
    checkOutput({tag, "_opb"},    32'(opb_o), 0);
    checkOutput({tag, "_init"},   32'(initVec), 0);
  endtask

  // Issues one request in the current cycle and checks the whole transaction.
  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    int s, v, u, armLow, L, dc, tlim, tcyc, firstValid, validCnt, busyLow;
    int initCnt[3];
    int expInit[3];
    logic launched, expErr, obsErr;
    logic [WIDTH-1:0] expRes, obsRes, obsOpa, obsOpb;
    s = cyc;
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    expInit = '{0, 0, 0};
    initCnt = '{0, 0, 0};
    expErr = 1'b0; expRes = '0; v = s + 2;
    case (op)
      3'd0: expRes = a + b;
      3'd1: expRes = a - b;
      3'd2, 3'd3, 3'd4: begin
        if (op == 3'd3 && b == '0) begin
          expErr = 1'b1;
        end else begin
          u = int'(op) - 2;
          armLow = s + 2;
          if (armLow >= winStart[u] && armLow < winEnd[u]) armLow = winEnd[u];
          L = armLow + 1;
          tlim = s + 2 + TIMEOUT;
          launched = (armLow < tlim);
          if (launched) begin
            expInit[u] = 1;
            tcyc = (L + 1 > tlim) ? L + 1 : tlim;
            dc = L + delayCfg[u];
          end else begin
            tcyc = tlim;
            dc = tlim;
          end
          if (launched && dc < tcyc) begin
            expRes = unitResult(u, a, b);
            v = dc + 1;
          end else begin
            expErr = 1'b1;
            v = tcyc + 1;
          end
        end
      end
      default: expErr = 1'b1;
    endcase

    firstValid = -1; validCnt = 0; busyLow = 0;
    obsErr = 1'b0; obsRes = '0; obsOpa = '0; obsOpb = '0;
    for (int c = s + 1; c <= v; c++) begin
      stepCycle();
      start_i = 1'($urandom);
      op_i = 3'($urandom);
      a_i = WIDTH'($urandom);
      b_i = WIDTH'($urandom);
      if (!busy_o) busyLow++;
      for (int k = 0; k < 3; k++) if (initVec[k]) initCnt[k]++;
      if (valid_o) begin
        validCnt++;
        if (firstValid < 0) begin
          firstValid = cyc;
          obsErr = err_o; obsRes = result_o; obsOpa = opa_o; obsOpb = opb_o;
        end
      end
    end
    stepCycle();
    start_i = 1'b0;

    checkOutput("valid_latency", 32'(firstValid - s), 32'(v - s));
    checkOutput("valid_count", 32'(validCnt), 1);
    checkOutput("busy_during", 32'(busyLow), 0);
    checkOutput("busy_after", 32'(busy_o), 0);
    checkOutput("valid_after", 32'(valid_o), 0);
    checkOutput("err", 32'(obsErr), 32'(expErr));
    checkOutput("result", 32'(obsRes), 32'(expRes));
    checkOutput("opa", 32'(obsOpa), 32'(a));
    checkOutput("opb", 32'(obsOpb), 32'(b));
    checkOutput("init_mul", 32'(initCnt[0]), 32'(expInit[0]));
    checkOutput("init_div", 32'(initCnt[1]), 32'(expInit[1]));
    checkOutput("init_raiz", 32'(initCnt[2]), 32'(expInit[2]));
  endtask

  initial begin
    int s, validSeen;
    logic [WIDTH-1:0] rb;
    rst_i = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) stepCycle();
    checkResetState("reset");
    rst_i = 1'b0;
    stepCycle();

    applyStimulus(3'd0, 16'hFFFF, 16'd1);
    stepCycle();
    applyStimulus(3'd1, 16'd3, 16'd5);

    delayCfg[2] = 20; holdCfg[2] = 31;
    applyStimulus(3'd4, 16'd144, 16'd0);
    applyStimulus(3'd4, 16'd1000, 16'd3);

    applyStimulus(3'd3, 16'd50, 16'd0);
    applyStimulus(3'd6, 16'd1, 16'd2);

    delayCfg[0] = 100000;
    applyStimulus(3'd2, 16'd7, 16'd9);
    delayCfg[0] = 8;
    applyStimulus(3'd2, 16'd300, 16'd301);

    delayCfg[1] = 30; holdCfg[1] = 5;
    s = cyc;
    op_i = 3'd3; a_i = 16'd1000; b_i = 16'd7; start_i = 1'b1;
    stepCycle();
    start_i = 1'b0;
    validSeen = 0;
    while (cyc < s + 6) begin
      stepCycle();
      if (valid_o) validSeen++;
    end
    rst_i = 1'b1;
    stepCycle();
    checkResetState("midwait");
    rst_i = 1'b0;
    repeat (4) begin
      stepCycle();
      if (valid_o) validSeen++;
    end
    checkOutput("abort_valid", 32'(validSeen), 0);
    applyStimulus(3'd0, 16'd10, 16'd20);

    for (int i = 0; i < 60; i++) begin
      for (int u = 0; u < 3; u++) begin
        delayCfg[u] = $urandom_range(1, 40);
        holdCfg[u]  = $urandom_range(1, 40);
      end
      repeat ($urandom_range(0, 3)) stepCycle();
      rb = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) rb = '0;
      applyStimulus(3'($urandom_range(0, 7)), WIDTH'($urandom), rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
